// File: rtl/video_fetch.sv
// Pixel-data fetch engine: requests NWORDS 16-bit words from the DRAM arbiter,
// assembles them into a cell buffer and hands the cell to the renderer on a cbeg boundary.
module video_fetch #(
  parameter int unsigned NWORDS = 4,
  parameter int unsigned CW     = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cbeg_i,
  input  logic                   pre_cbeg_i,
  input  logic                   vpix_i,
  input  logic                   fetch_start_i,
  input  logic                   fetch_end_i,
  output logic                   video_go_o,
  input  logic                   video_next_i,
  input  logic                   video_strobe_i,
  input  logic [15:0]            video_data_i,
  output logic [16*NWORDS-1:0]   pic_bits_o,
  output logic                   fetch_sync_o,
  output logic                   err_underrun_o,
  output logic                   err_overrun_o
);

  localparam logic [CW-1:0] NwCnt   = CW'(NWORDS);
  localparam logic [CW-1:0] LastCnt = CW'(NWORDS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StFull} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         req_cnt_q, req_cnt_d;
  logic [CW-1:0]         stb_cnt_q, stb_cnt_d;
  logic [16*NWORDS-1:0]  fetch_buf_q, fetch_buf_d;
  logic [16*NWORDS-1:0]  pic_bits_q, pic_bits_d;
  logic                  load_pend_q, load_pend_d;
  logic                  video_go_q, video_go_d;
  logic                  fetch_sync_q, fetch_sync_d;
  logic                  underrun_q, underrun_d;
  logic                  overrun_q, overrun_d;
  logic                  load, start_ok;

  // cbeg itself is implied: a load on the pre_cbeg edge is visible in the cbeg cycle.
  logic unused_cbeg;
  assign unused_cbeg = cbeg_i;

  always_comb begin
    state_d      = state_q;
    req_cnt_d    = req_cnt_q;
    stb_cnt_d    = stb_cnt_q;
    fetch_buf_d  = fetch_buf_q;
    pic_bits_d   = pic_bits_q;
    load_pend_d  = load_pend_q;
    underrun_d   = 1'b0;
    overrun_d    = 1'b0;
    start_ok     = 1'b0;
    // A fetch_end arriving together with pre_cbeg loads on that same edge.
    load = pre_cbeg_i & (load_pend_q | ((state_q == StFull) & fetch_end_i));

    unique case (state_q)
      StIdle: begin
        if (fetch_end_i) underrun_d = 1'b1;
        if (fetch_start_i && vpix_i) start_ok = 1'b1;
      end
      StFetch: begin
        if (fetch_end_i) underrun_d = 1'b1;
        if (fetch_start_i) overrun_d = 1'b1;
        if (!vpix_i) begin
          state_d = StIdle;
        end else begin
          if (video_next_i && video_go_q) req_cnt_d = req_cnt_q + 1'b1;
          if (video_strobe_i) begin
            fetch_buf_d[16*stb_cnt_q +: 16] = video_data_i;
            stb_cnt_d = stb_cnt_q + 1'b1;
            if (stb_cnt_q == LastCnt) state_d = StFull;
          end
        end
      end
      StFull: begin
        if (fetch_end_i) load_pend_d = 1'b1;
        if (load) begin
          pic_bits_d  = fetch_buf_q;
          load_pend_d = 1'b0;
          state_d     = StIdle;
          if (fetch_start_i && vpix_i) start_ok = 1'b1;
        end else if (fetch_start_i) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_ok) begin
      state_d   = StFetch;
      req_cnt_d = '0;
      stb_cnt_d = '0;
    end

    fetch_sync_d = load;
    video_go_d   = (state_d == StFetch) && (req_cnt_d < NwCnt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      req_cnt_q    <= '0;
      stb_cnt_q    <= '0;
      fetch_buf_q  <= '0;
      pic_bits_q   <= '0;
      load_pend_q  <= 1'b0;
      video_go_q   <= 1'b0;
      fetch_sync_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_cnt_q    <= req_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      fetch_buf_q  <= fetch_buf_d;
      pic_bits_q   <= pic_bits_d;
      load_pend_q  <= load_pend_d;
      video_go_q   <= video_go_d;
      fetch_sync_q <= fetch_sync_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
    end
  end

  assign video_go_o     = video_go_q;
  assign pic_bits_o     = pic_bits_q;
  assign fetch_sync_o   = fetch_sync_q;
  assign err_underrun_o = underrun_q;
  assign err_overrun_o  = overrun_q;

endmodule

// File: tb/tb_video_fetch.sv
// Bench for video_fetch: directed cell scenarios, then randomized traffic checked every cycle
// against a queue-based model of the fetch/load rules.
module tb_video_fetch;

  localparam int unsigned NW = 4;
  localparam int unsigned PW = 16 * NW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cbeg = 1'b0, pre_cbeg = 1'b0, vpix = 1'b1;
  logic          fetch_start = 1'b0, fetch_end = 1'b0;
  logic          video_next = 1'b0, video_strobe = 1'b0;
  logic [15:0]   video_data = '0;
  logic          video_go, fetch_sync, err_underrun, err_overrun;
  logic [PW-1:0] pic_bits;

  video_fetch #(.NWORDS(NW), .CW(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cbeg_i         (cbeg),
    .pre_cbeg_i     (pre_cbeg),
    .vpix_i         (vpix),
    .fetch_start_i  (fetch_start),
    .fetch_end_i    (fetch_end),
    .video_go_o     (video_go),
    .video_next_i   (video_next),
    .video_strobe_i (video_strobe),
    .video_data_i   (video_data),
    .pic_bits_o     (pic_bits),
    .fetch_sync_o   (fetch_sync),
    .err_underrun_o (err_underrun),
    .err_overrun_o  (err_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pending = 0;
  bit checking = 1'b0;

  // Model: a cell in progress is a queue of captured words; it is full at NW words.
  bit            m_active = 1'b0;
  bit            m_armed = 1'b0;
  int            m_granted = 0;
  logic [15:0]   m_words[$];
  logic          e_go = 1'b0, e_sync = 1'b0, e_under = 1'b0, e_over = 1'b0;
  logic [PW-1:0] e_pic = '0;

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  function automatic logic [PW-1:0] pack_words();
    logic [PW-1:0] p = '0;
    foreach (m_words[i]) p[16*i +: 16] = m_words[i];
    return p;
  endfunction

  task automatic model_step();
    bit full, fetching, do_load, start, nxt_ok;
    if (rst) begin
      m_active = 0; m_armed = 0; m_granted = 0; m_words.delete();
      e_go = 0; e_sync = 0; e_under = 0; e_over = 0; e_pic = '0;
      return;
    end
    full     = m_active && (m_words.size() == NW);
    fetching = m_active && !full;
    do_load  = pre_cbeg && full && (m_armed || fetch_end);
    start    = fetch_start && vpix && (!m_active || do_load);
    nxt_ok   = video_next && e_go;
    e_sync   = do_load;
    e_under  = fetch_end && !full;
    e_over   = fetch_start && (fetching || (full && !do_load));
    if (do_load) begin
      e_pic = pack_words();
      m_armed = 0; m_active = 0; m_words.delete();
    end else if (full && fetch_end) begin
      m_armed = 1;
    end
    if (fetching) begin
      if (!vpix) begin
        m_active = 0; m_words.delete();
      end else begin
        if (nxt_ok) m_granted++;
        if (video_strobe) m_words.push_back(video_data);
      end
    end
    if (start) begin
      m_active = 1; m_granted = 0; m_words.delete();
    end
    e_go = m_active && (m_words.size() < NW) && (m_granted < NW);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    pre_cbeg = (cyc % 4 == 2);
    cbeg     = (cyc % 4 == 3);
    fetch_start = 0; fetch_end = 0; video_next = 0; video_strobe = 0;
  endtask

  task automatic strobe(input logic [15:0] d);
    video_strobe = 1; video_data = d;
    tick();
  endtask

  task automatic wait_sync(input string tag);
    int n = 0;
    while (!fetch_sync && n < 8) begin
      tick();
      n++;
    end
    chk(tag, PW'(fetch_sync), PW'(1));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("video_go", PW'(video_go), PW'(e_go));
      chk("pic_bits", pic_bits, e_pic);
      chk("fetch_sync", PW'(fetch_sync), PW'(e_sync));
      chk("err_underrun", PW'(err_underrun), PW'(e_under));
      chk("err_overrun", PW'(err_overrun), PW'(e_over));
      if (fetch_sync) chk("sync_with_cbeg", PW'(cbeg), PW'(1));
    end
  end

  initial begin
    logic [PW-1:0] cell_a, cell_b;
    cell_a = 64'h4444_3333_2222_1111;
    cell_b = 64'h8888_7777_6666_5555;

    rst = 1; tick(); tick(); rst = 0;
    checking = 1;
    chk("reset_pic", pic_bits, '0);
    chk("reset_go", PW'(video_go), PW'(0));

    // Basic cell: four accepts, four words, fetch_end, load on pre_cbeg.
    vpix = 1; fetch_start = 1; tick();
    chk("go_after_start", PW'(video_go), PW'(1));
    for (int i = 0; i < 4; i++) begin
      video_next = 1; tick();
    end
    chk("go_after_4_accepts", PW'(video_go), PW'(0));
    strobe(16'h1111); strobe(16'h2222); strobe(16'h3333); strobe(16'h4444);
    fetch_end = 1; tick();
    wait_sync("first_load_sync");
    chk("first_load_pic", pic_bits, cell_a);
    chk("model_pic_a", e_pic, cell_a);
    tick();
    chk("sync_falls", PW'(fetch_sync), PW'(0));

    // Underrun after two words, then complete the cell.
    fetch_start = 1; tick();
    strobe(16'h5555); strobe(16'h6666);
    fetch_end = 1; tick();
    chk("underrun_pulse", PW'(err_underrun), PW'(1));
    chk("underrun_pic_holds", pic_bits, cell_a);
    chk("underrun_no_sync", PW'(fetch_sync), PW'(0));
    fetch_start = 1; tick();
    chk("overrun_pulse", PW'(err_overrun), PW'(1));
    strobe(16'h7777); strobe(16'h8888);
    while (pre_cbeg) tick();
    fetch_end = 1; tick();
    while (!pre_cbeg) tick();
    fetch_start = 1; tick();
    chk("load_start_sync", PW'(fetch_sync), PW'(1));
    chk("load_start_pic", pic_bits, cell_b);
    chk("load_start_go", PW'(video_go), PW'(1));

    // Reset mid-burst while strobes keep arriving.
    video_next = 1; strobe(16'h9999);
    rst = 1; video_strobe = 1; tick();
    rst = 0;
    chk("rst_pic", pic_bits, '0);
    chk("rst_go", PW'(video_go), PW'(0));
    strobe(16'hAAAA);
    chk("rst_stale_strobe_go", PW'(video_go), PW'(0));

    // Randomized traffic.
    pending = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(399) == 0);
      if (vpix) vpix = ($urandom_range(79) != 0);
      else      vpix = ($urandom_range(7) == 0);
      fetch_start = ($urandom_range(11) == 0);
      fetch_end   = ($urandom_range(9) == 0);
      if (e_go) video_next = ($urandom_range(9) < 7);
      else      video_next = ($urandom_range(32) == 0);
      if (video_next && e_go) pending++;
      if (pending > 0 && $urandom_range(9) < 6) begin
        video_strobe = 1; pending--;
      end else begin
        video_strobe = ($urandom_range(49) == 0);
      end
      video_data = 16'($urandom);
      if (rst) pending = 0;
      tick();
    end

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_fetch.md
Name: video_fetch

Overview:
- Producer side of the pixel-data path that feeds the video renderer.
- Requests 16-bit words from the DRAM arbiter during active picture and assembles NWORDS words into a fetch buffer.
- Transfers the completed buffer to pic_bits at a cell boundary.
- Pulses fetch_sync in the same cycle as cbeg, so the renderer restarts its pixel and group counters on fresh data.

Parameters:
- NWORDS, 4: words per cell; pic_bits width is 16*NWORDS (64 at default).
- CW, 3: width of the request and strobe counters; must satisfy 2^CW > NWORDS.

Ports:
- clk  in  1  28 MHz system clock.
- rst  in  1  synchronous reset, active-high.
- cbeg  in  1  pixel-phase strobe.
- pre_cbeg  in  1  strobe one cycle before cbeg.
- vpix  in  1  active-picture window.
- fetch_start  in  1  one-cycle pulse: begin fetching the next cell.
- fetch_end  in  1  one-cycle pulse: cell boundary reached, current cell consumed.
- video_go  out  1  request to the DRAM arbiter.
- video_next  in  1  arbiter accepted one request (one-cycle pulse).
- video_strobe  in  1  video_data valid this cycle.
- video_data  in  16  DRAM read data.
- pic_bits  out  16*NWORDS  rendered cell data.
- fetch_sync  out  1  one-cycle pulse, coincident with cbeg, marking new pic_bits.
- err_underrun  out  1  one-cycle pulse: fetch_end arrived while the buffer was not full.
- err_overrun  out  1  one-cycle pulse: fetch_start was rejected.

Behaviour:
- Reset: state=IDLE; pic_bits=0; fetch_buf=0; req_cnt=0; stb_cnt=0; load_pend=0; video_go=0; fetch_sync=0; both error outputs 0. Reset overrides every other input in that cycle, including mid-burst; stale strobes after reset are ignored because state is IDLE.
- State machine, states IDLE, FETCH, FULL:
  - IDLE -> FETCH on fetch_start & vpix; clears req_cnt and stb_cnt. fetch_start with vpix=0 is ignored silently.
  - FETCH -> FULL on the video_strobe that makes stb_cnt reach NWORDS.
  - FETCH -> IDLE if vpix=0 (abort). Partial fetch_buf is discarded; no error is reported.
  - FULL -> IDLE when the load executes (see below).
- video_go (registered): 1 in FETCH while req_cnt < NWORDS, else 0.
  - req_cnt increments on video_next when video_go=1.
  - video_next with video_go=0 is ignored.
- Data capture: on video_strobe in FETCH, fetch_buf[16*stb_cnt +: 16] <= video_data, then stb_cnt++.
  - Word 0 lands in bits 15:0.
  - Strobes outside FETCH are ignored.
  - stb_cnt never exceeds NWORDS.
- Load arming:
  - fetch_end in FULL sets load_pend.
  - fetch_end in IDLE or FETCH pulses err_underrun next cycle; load_pend stays 0; pic_bits holds; no fetch_sync is generated.
- Load: at the clk edge where pre_cbeg=1 and load_pend=1:
  - pic_bits <= fetch_buf; fetch_sync <= 1; load_pend <= 0; state -> IDLE.
  - pic_bits and fetch_sync are therefore valid in the cbeg cycle.
  - fetch_sync falls the following cycle.
  - Latency: fetch_end to fetch_sync is 1 to one full pixel period, governed by pre_cbeg.
- Simultaneous events:
  - fetch_end and pre_cbeg in the same cycle while FULL: the load occurs at that same edge.
  - fetch_start in the load cycle is accepted; state goes directly to FETCH and counters clear.
  - fetch_start in FETCH, or in FULL outside a load cycle: ignored, err_overrun pulses next cycle.
  - video_next and video_strobe in the same cycle: both are counted.
- Width rules: counters are unsigned CW bits and never wrap. pic_bits changes only on a load.

Test Plan:
- Reset, vpix=1, fetch_start, video_next x4, strobes with 1111,2222,3333,4444, fetch_end, pre_cbeg -> video_go high for exactly 4 accepts; pic_bits=4444_3333_2222_1111; fetch_sync high only in the cbeg cycle.
- fetch_end after only 2 strobes -> err_underrun pulse; pic_bits unchanged; no fetch_sync; completing 2 more strobes then fetch_end loads normally.
- fetch_start during FETCH -> err_overrun pulse; capture continues uninterrupted; counters not cleared.
- vpix drops after 1 strobe -> IDLE, video_go=0; next fetch_start with data AAAA.. loads only new words.
- fetch_start coincident with the load edge -> load completes, new burst begins, video_go=1 the next cycle.
- rst asserted mid-burst with strobes continuing -> all outputs 0 next cycle; strobes ignored.
